// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the multiplexed 7-segment
//                display path: segment bit order, blank/dash codes, the
//                BCD-to-segment table, scan state encoding and the snapshot
//                record that freezes one frame's worth of display data.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Segment bit positions within the 7-bit segment bus (a is the MSB).
  localparam int SEG_W     = 7;
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam int NUM_DIGITS = 6;

  // All segments dark, and a lone middle bar used to flag a non-BCD code.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b000_0000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'(1) << SEG_G_BIT;

  // Active-high patterns, bit order a b c d e f g.
  localparam logic [SEG_W-1:0] SEG_0 = 7'b111_1110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b011_0000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b110_1101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b111_1001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b011_0011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b101_1011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b101_1111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b111_0000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b111_1111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b111_1011;

  // Full 16-entry table; codes 10..15 show a dash so a bad digit is visible.
  localparam logic [SEG_W-1:0] BCD_SEG_LUT [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

  // Scan phases: GAP keeps every digit dark, SHOW lights one digit.
  typedef enum logic [0:0] {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_e;

  // Per-frame snapshot of everything that affects what is displayed.
  typedef struct packed {
    logic                        lz_blank;
    logic                        colon;
    logic [NUM_DIGITS-1:0][3:0]  digit;
  } shadow_t;

  // One-hot digit enable; indices beyond the last digit give all zeros.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
    return NUM_DIGITS'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational BCD to 7-segment decoder (active-high, bit6=a
//                .. bit0=g). Non-BCD codes decode to a dash.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  // Straight table lookup; every 4-bit code has a defined pattern.
  always_comb begin
    seg = BCD_SEG_LUT[bcd];
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for a six-digit 7-segment display.
//                Each digit gets a dark GAP phase followed by a lit SHOW
//                phase. All inputs are snapshotted once per frame so a frame
//                never mixes two different times. Outputs are registered and
//                computed from next-state values, so they line up exactly
//                with the state register.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_GAP      = 2,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic       colon,
  input  logic       lz_blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_en,
  output logic       frame_tick
);

  // Counter wide enough for the longer of the two phases, at least one bit.
  localparam int MAX_DIV = (SCAN_DIV > BLANK_GAP) ? SCAN_DIV : BLANK_GAP;
  localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

  // Polarity masks; XOR with these converts active-high to pin levels.
  localparam logic                  POL          = (SEG_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]      SEG_POL      = {SEG_W{POL}};
  localparam logic [NUM_DIGITS-1:0] DIG_POL      = {NUM_DIGITS{POL}};

  scan_state_e           state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  shadow_t               shadow_q, shadow_d;
  logic                  snap;

  logic [3:0]            digit_sel;
  logic [SEG_W-1:0]      seg_dec;

  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_tick_q, frame_tick_d;

  // Scan state register: phase, digit index and phase counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= GAP;
      idx_q   <= 3'd0;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: GAP then SHOW for each digit, wrapping after digit 5.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (idx_q > IDX_LAST) begin
      // Unreachable index: restart cleanly at the first digit's gap.
      state_d = GAP;
      idx_d   = 3'd0;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = SHOW;
            cnt_d   = CNT_ZERO;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = GAP;
            cnt_d   = CNT_ZERO;
            idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
          end
        end
        default: begin
          state_d = GAP;
          idx_d   = 3'd0;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Frame snapshot: load all display inputs only at the very start of a frame.
  always_comb begin
    snap     = (state_q == GAP) && (idx_q == 3'd0) && (cnt_q == CNT_ZERO);
    shadow_d = shadow_q;
    if (snap) begin
      shadow_d.digit    = {d5, d4, d3, d2, d1, d0};
      shadow_d.colon    = colon;
      shadow_d.lz_blank = lz_blank;
    end
  end

  // Snapshot register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Select the digit that will be lit in the coming cycle.
  always_comb begin
    case (idx_d)
      3'd0:    digit_sel = shadow_d.digit[0];
      3'd1:    digit_sel = shadow_d.digit[1];
      3'd2:    digit_sel = shadow_d.digit[2];
      3'd3:    digit_sel = shadow_d.digit[3];
      3'd4:    digit_sel = shadow_d.digit[4];
      3'd5:    digit_sel = shadow_d.digit[5];
      default: digit_sel = 4'd0;
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd (digit_sel),
    .seg (seg_dec)
  );

  // Output decode from next-state values, then polarity applied before the flop.
  always_comb begin
    seg_d        = SEG_BLANK;
    dp_d         = 1'b0;
    dig_en_d     = '0;
    frame_tick_d = 1'b0;
    if (state_d == SHOW) begin
      dig_en_d = digit_onehot(idx_d);
      seg_d    = seg_dec;
      // Leading-zero suppression keeps the enable so brightness stays even.
      if ((idx_d == IDX_LAST) && shadow_d.lz_blank && (shadow_d.digit[5] == 4'd0)) begin
        seg_d = SEG_BLANK;
      end
      // Colon dots sit on the minutes-units and hours-units digits.
      dp_d         = shadow_d.colon && ((idx_d == 3'd2) || (idx_d == 3'd4));
      frame_tick_d = (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
    end
    seg_d    = seg_d ^ SEG_POL;
    dp_d     = dp_d ^ POL;
    dig_en_d = dig_en_d ^ DIG_POL;
  end

  // Output register; reset drives the inactive pin levels.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg_q        <= SEG_POL;
      dp_q         <= POL;
      dig_en_q     <= DIG_POL;
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Scoreboard bench for seg7_scan_driver (SCAN_DIV=4,
//                BLANK_GAP=1). Stimulus queues hand-computed expectations
//                stamped with a cycle number; a monitor on the falling edge
//                compares them against an active-high and an active-low DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, d4 = '0, d5 = '0;
  logic       colon = 1'b0;
  logic       lz_blank = 1'b0;

  logic [6:0] seg, seg_n;
  logic       dp, dp_n;
  logic [5:0] dig_en, dig_en_n;
  logic       frame_tick, frame_tick_n;

  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_GAP(1), .SEG_ACTIVE_LOW(0)) u_dut (
    .clk(clk), .clr(clr), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .colon(colon), .lz_blank(lz_blank),
    .seg(seg), .dp(dp), .dig_en(dig_en), .frame_tick(frame_tick)
  );

  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_GAP(1), .SEG_ACTIVE_LOW(1)) u_dut_n (
    .clk(clk), .clr(clr), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .colon(colon), .lz_blank(lz_blank),
    .seg(seg_n), .dp(dp_n), .dig_en(dig_en_n), .frame_tick(frame_tick_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    string       name;
    logic [5:0]  en;
    logic [6:0]  sg;
    logic        p;
    logic        t;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned tcyc = 0;
  int unsigned base = 0;

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic exp_abs(input int unsigned at, input string nm, input logic [5:0] en,
                         input logic [6:0] sg, input logic p, input logic t);
    sb.push_back('{at: at, name: nm, en: en, sg: sg, p: p, t: t});
  endtask

  task automatic exp_at(input int n, input string nm, input logic [5:0] en,
                        input logic [6:0] sg, input logic p, input logic t);
    exp_abs(base + n, nm, en, sg, p, t);
  endtask

  task automatic wait_to(input int n);
    while (tcyc < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clr = 1'b1;
    exp_abs(tcyc, "reset", 6'b000000, 7'b0000000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_release();
    @(posedge clk);
    #1;
    clr  = 1'b0;
    base = tcyc;
  endtask

  // Monitor: one-hot rule every cycle, plus scoreboard entries due this cycle.
  exp_t e;
  always @(negedge clk) begin
    checks++;
    if ($countones(dig_en) > 1) begin
      failures++;
      $display("FAIL onehot cyc=%0d dig_en=%b", tcyc, dig_en);
    end
    while (sb.size() > 0 && sb[0].at < tcyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s missed: due cyc=%0d now=%0d", e.name, e.at, tcyc);
    end
    if (sb.size() > 0 && sb[0].at == tcyc) begin
      e = sb.pop_front();
      checks++;
      if (dig_en !== e.en || seg !== e.sg || dp !== e.p || frame_tick !== e.t) begin
        failures++;
        $display("FAIL %s: got en=%b seg=%b dp=%b tick=%b, want en=%b seg=%b dp=%b tick=%b",
                 e.name, dig_en, seg, dp, frame_tick, e.en, e.sg, e.p, e.t);
      end
      checks++;
      if (dig_en_n !== ~e.en || seg_n !== ~e.sg || dp_n !== ~e.p || frame_tick_n !== e.t) begin
        failures++;
        $display("FAIL %s_lowpol: got en=%b seg=%b dp=%b tick=%b, want en=%b seg=%b dp=%b tick=%b",
                 e.name, dig_en_n, seg_n, dp_n, frame_tick_n, ~e.en, ~e.sg, ~e.p, e.t);
      end
    end
  end

  initial begin
    // Run 1: basic scan, digit order, frame tick and snapshot isolation.
    d5 = 4'd1; d4 = 4'd2; d3 = 4'd3; d2 = 4'd4; d1 = 4'd5; d0 = 4'd6;
    colon = 1'b0; lz_blank = 1'b0;
    @(posedge clk);
    #1;
    exp_abs(tcyc, "reset_init", 6'b000000, 7'b0000000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    do_release();
    exp_at(0,  "r1_gap0",   6'b000000, 7'b0000000, 1'b0, 1'b0);
    exp_at(1,  "r1_d0a",    6'b000001, 7'b1011111, 1'b0, 1'b0);
    exp_at(4,  "r1_d0b",    6'b000001, 7'b1011111, 1'b0, 1'b0);
    exp_at(5,  "r1_gap1",   6'b000000, 7'b0000000, 1'b0, 1'b0);
    exp_at(6,  "r1_d1a",    6'b000010, 7'b1011011, 1'b0, 1'b0);
    exp_at(9,  "r1_d1b",    6'b000010, 7'b1011011, 1'b0, 1'b0);
    exp_at(11, "r1_d2",     6'b000100, 7'b0110011, 1'b0, 1'b0);
    exp_at(16, "r1_d3",     6'b001000, 7'b1111001, 1'b0, 1'b0);
    exp_at(21, "r1_d4",     6'b010000, 7'b1101101, 1'b0, 1'b0);
    exp_at(28, "r1_d5",     6'b100000, 7'b0110000, 1'b0, 1'b0);
    exp_at(29, "r1_tick",   6'b100000, 7'b0110000, 1'b0, 1'b1);
    exp_at(30, "r1_wrap",   6'b000000, 7'b0000000, 1'b0, 1'b0);
    exp_at(31, "r1_new_d0", 6'b000001, 7'b1111011, 1'b0, 1'b0);
    exp_at(34, "r1_new_d0b",6'b000001, 7'b1111011, 1'b0, 1'b0);
    exp_at(35, "r1_gap7",   6'b000000, 7'b0000000, 1'b0, 1'b0);
    wait_to(12);
    d0 = 4'd9;
    wait_to(36);

    // Run 2: colon dots, invalid code dash, leading-zero blank.
    do_reset();
    d5 = 4'd0; d4 = 4'd7; d3 = 4'd8; d2 = 4'hC; d1 = 4'd3; d0 = 4'd0;
    colon = 1'b1; lz_blank = 1'b1;
    do_release();
    exp_at(0,  "r2_gap0",   6'b000000, 7'b0000000, 1'b0, 1'b0);
    exp_at(1,  "r2_d0",     6'b000001, 7'b1111110, 1'b0, 1'b0);
    exp_at(6,  "r2_d1",     6'b000010, 7'b1111001, 1'b0, 1'b0);
    exp_at(11, "r2_d2dash", 6'b000100, 7'b0000001, 1'b1, 1'b0);
    exp_at(14, "r2_d2end",  6'b000100, 7'b0000001, 1'b1, 1'b0);
    exp_at(15, "r2_gap3",   6'b000000, 7'b0000000, 1'b0, 1'b0);
    exp_at(16, "r2_d3",     6'b001000, 7'b1111111, 1'b0, 1'b0);
    exp_at(21, "r2_d4",     6'b010000, 7'b1110000, 1'b1, 1'b0);
    exp_at(26, "r2_lzb",    6'b100000, 7'b0000000, 1'b0, 1'b0);
    exp_at(29, "r2_tick",   6'b100000, 7'b0000000, 1'b0, 1'b1);
    wait_to(30);

    // Run 3: asynchronous clear mid-frame while digit 3 is lit.
    do_reset();
    d5 = 4'd0; d4 = 4'd9; d3 = 4'd4; d2 = 4'd1; d1 = 4'd2; d0 = 4'd8;
    colon = 1'b0; lz_blank = 1'b0;
    do_release();
    exp_at(0,  "r3_gap0",   6'b000000, 7'b0000000, 1'b0, 1'b0);
    exp_at(1,  "r3_d0",     6'b000001, 7'b1111111, 1'b0, 1'b0);
    exp_at(16, "r3_d3",     6'b001000, 7'b0110011, 1'b0, 1'b0);
    exp_at(17, "r3_clrmid", 6'b000000, 7'b0000000, 1'b0, 1'b0);
    wait_to(17);
    #1;
    clr = 1'b1;
    d0  = 4'd5;
    repeat (2) @(posedge clk);

    // Run 4: restart after the clear, fresh snapshot, lz_blank=0 shows zero.
    do_release();
    exp_at(0,  "r4_gap0",   6'b000000, 7'b0000000, 1'b0, 1'b0);
    exp_at(1,  "r4_resnap", 6'b000001, 7'b1011011, 1'b0, 1'b0);
    exp_at(26, "r4_d5zero", 6'b100000, 7'b1111110, 1'b0, 1'b0);
    exp_at(29, "r4_tick",   6'b100000, 7'b1111110, 1'b0, 1'b1);
    exp_at(30, "r4_wrap",   6'b000000, 7'b0000000, 1'b0, 1'b0);
    exp_at(31, "r4_d0",     6'b000001, 7'b1011011, 1'b0, 1'b0);
    wait_to(32);

    repeat (2) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t left;
      left = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s unchecked: due cyc=%0d now=%0d", left.name, left.at, tcyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the six BCD time digits (sec units/tens, min units/tens, hour units/tens) produced by the real-time-clock counter block.
- Drives one physical multiplexed 7-segment display with a shared segment bus and one-hot digit enables.
- Time-multiplexes the digits with a prescaled scan counter and inserts anti-ghosting blank gaps.
- Snapshots all digits once per frame so a displayed time never tears mid-scan.

Parameters:
- SCAN_DIV, 1000, clock cycles each digit is lit (SHOW phase); legal range >= 1.
- BLANK_GAP, 2, clock cycles all digits are dark before each digit (GAP phase); legal range >= 1.
- SEG_ACTIVE_LOW, 0, 1 inverts seg, dp and dig_en at the outputs, including their reset levels.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  asynchronous, active-high reset.
- d0  in  4  BCD seconds units.
- d1  in  4  BCD seconds tens.
- d2  in  4  BCD minutes units.
- d3  in  4  BCD minutes tens.
- d4  in  4  BCD hours units.
- d5  in  4  BCD hours tens.
- colon  in  1  colon request; lights dp on digits 2 and 4.
- lz_blank  in  1  1 blanks the hour-tens digit when it is 0.
- seg  out  7  segments; bit6=a … bit0=g. Active-high pattern for "0" is 1111110.
- dp  out  1  decimal point / colon segment.
- dig_en  out  6  one-hot digit enable; bit i selects digit i.
- frame_tick  out  1  one-cycle pulse on the last SHOW cycle of digit 5.

Behaviour:
- Reset (clr=1, asynchronous):
  - state=GAP, idx=0, cnt=0, shadow registers=0.
  - Outputs at inactive level: seg=0000000, dp=0, dig_en=000000, frame_tick=0 (all inverted when SEG_ACTIVE_LOW=1).
  - Reset mid-frame aborts the scan immediately; outputs go inactive asynchronously.
- State machine, two states:
  - GAP: cnt counts 0..BLANK_GAP-1. At cnt=BLANK_GAP-1: go to SHOW, cnt=0.
  - SHOW: cnt counts 0..SCAN_DIV-1. At cnt=SCAN_DIV-1: go to GAP, cnt=0, idx=(idx==5)?0:idx+1.
- Frame length is 6*(BLANK_GAP+SCAN_DIV) cycles. The first frame after reset release starts in GAP, idx=0.
- Snapshot: on any rising edge with state=GAP, idx=0, cnt=0, shadow d0..d5, colon and lz_blank load from the inputs. This is the first edge after reset release and once per frame thereafter. Input changes at any other time are invisible until the next snapshot.
- Outputs are Moore and registered: they reflect the current registered state/idx/shadow with no added latency relative to the state register.
  - GAP: dig_en=000000, seg=0000000, dp=0.
  - SHOW: dig_en=one-hot(idx); seg=decode(shadow d[idx]); dp=shadow colon when idx is 2 or 4, else 0.
- Decode table (active-high):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - codes 10..15 = 0000001 (dash, g only) to flag an invalid input.
- Leading-zero blank: idx=5 in SHOW with shadow lz_blank=1 and shadow d5=0 gives seg=0000000. dig_en is still asserted so the duty cycle is unchanged.
- frame_tick=1 exactly on the cycle where state=SHOW, idx=5, cnt=SCAN_DIV-1.
- Counter widths:
  - cnt is clog2(max(SCAN_DIV,BLANK_GAP)) bits, minimum 1.
  - idx is 3 bits; values 6 and 7 are unreachable; if ever seen, the next state is GAP with idx=0.
- dig_en is never multi-hot, and is never nonzero during GAP.

Decomposition:
- Shared package seg7_pkg:
  - segment bit-order constants.
  - SEG_BLANK=0000000 and SEG_DASH=0000001.
  - the 16-entry BCD-to-segment pattern constants.
  - state enum {GAP, SHOW}.
- One combinational sub-module bcd_to_seg7 (4-bit in, 7-bit out), reusable by the clock block's units-digit output.
- Scan FSM, counters, shadow registers and polarity inversion stay in seg7_scan_driver.

Test Plan (SCAN_DIV=4, BLANK_GAP=1 unless stated):
- Reset then release, inputs d5..d0=1,2,3,4,5,6 →
  - cycle 0 is GAP with dig_en=000000.
  - cycles 1-4: dig_en=000001, seg=1011111 ("6").
  - cycle 5: GAP.
  - cycles 6-9: dig_en=000010, seg=1011011 ("5").
  - frame_tick high only at cycle 29; the frame repeats from cycle 30.
- Change d0 from 6 to 9 at cycle 12 → digit 0 in the current frame still shows "6"; cycles 31-34 show 1111011.
- d5=0 with lz_blank=1 → during idx=5 SHOW, dig_en=100000 and seg=0000000. Same with lz_blank=0 → seg=1111110.
- colon=1, d2=0xC → dp=1 only during idx 2 and idx 4 SHOW; digit 2 seg=0000001.
- SEG_ACTIVE_LOW=1 → reset gives seg=1111111, dig_en=111111, dp=1; digit "0" drives seg=0000001 with dig_en=111110.
- Assert clr at cycle 17 (idx=3 SHOW) → outputs inactive in the same cycle. After release, the scan restarts at idx=0 GAP and re-snapshots.
